bp_fe_fetch_queue: RTL and testbench
====================================

// Module: bp_fe_fetch_queue
// PURPOSE
//  Buffers fetched {PC, instruction} packets between the front-end fetch stage and the back-end
//  issue stage. The FE pushes one packet per accepted valid/ready beat; the BE pops with
//  valid-yumi. A BE redirect (flush) discards all buffered packets in one cycle. Output PCs are
//  sign-extended from the vaddr width to the effective-address width, and each packet is tagged
//  with a misalignment flag.
// PARAMETERS
//  vaddr_width_p  22  FE virtual PC width (bp_vaddr_width_gp)
//  eaddr_width_p  64  BE effective-address width (bp_eaddr_width_gp)
//  instr_width_p  32  instruction width (bp_instr_width_gp)
//  els_p          8   queue depth; power of 2, >= 2
// PORTS
//  clk_i                  in   1                     clock
//  reset_i                in   1                     asynchronous, active-high reset
//  flush_i                in   1                     BE redirect: discard all queued entries
//  fe_v_i                 in   1                     FE packet valid
//  fe_pc_i                in   vaddr_width_p         FE packet PC
//  fe_instr_i             in   instr_width_p         FE packet instruction
//  fe_ready_o             out  1                     queue can accept a packet this cycle
//  fe_queue_v_o           out  1                     head packet valid
//  fe_queue_pc_o          out  eaddr_width_p         head PC, sign-extended
//  fe_queue_instr_o       out  instr_width_p         head instruction
//  fe_queue_misaligned_o  out  1                     head PC[1:0] != 0
//  fe_queue_yumi_i        in   1                     BE consumes the head packet
//  count_o                out  $clog2(els_p+1)       number of valid entries
// BEHAVIOUR
//  - Reset (async, active-high): rd/wr pointers = 0, count = 0. While reset_i = 1:
//    fe_ready_o = 0, fe_queue_v_o = 0, count_o = 0. Storage array is not reset.
//  - Enqueue when fe_v_i & fe_ready_o. Write at wr_ptr; wr_ptr increments modulo els_p.
//  - fe_ready_o = ~reset_i & (count != els_p); combinational only on count, never on yumi.
//    A full queue therefore refuses a push even when a pop happens in the same cycle.
//  - fe_queue_v_o = (count != 0). There is no fall-through: a packet pushed in cycle N is first
//    visible in cycle N+1. Minimum push-to-pop latency is 1 cycle.
//  - Dequeue on fe_queue_yumi_i; rd_ptr increments modulo els_p. fe_queue_yumi_i is legal only
//    when fe_queue_v_o = 1; this is checked by an assertion and the pop is ignored if violated.
//  - Simultaneous push and pop (non-full, non-empty): count is unchanged and both pointers
//    advance.
//  - Flush: on the clock edge where flush_i = 1, rd_ptr = wr_ptr = 0 and count = 0. A push or
//    pop in the same cycle is dropped. fe_ready_o stays combinational and may be 1 during a flush
//    cycle, but the beat is discarded. The FE must resend after the redirect.
//  - Head outputs read from rd_ptr.
//      fe_queue_pc_o = {{(eaddr_width_p-vaddr_width_p){pc[vaddr_width_p-1]}}, pc}.
//      fe_queue_misaligned_o = |pc[1:0].
//    When fe_queue_v_o = 0, the pc, instr and misaligned outputs are forced to 0.
//  - Pointer width is $clog2(els_p). count has a separate counter, so full and empty are
//    unambiguous when pointers are equal.
// TESTING
//  1. Reset mid-stream: fill 3 entries, then pulse reset_i asynchronously between edges.
//     -> v_o = 0, count_o = 0 and ready_o = 0 immediately. After release, ready_o = 1 and the
//     old entries are never produced.
//  2. Sign-extend and alignment: push pc = 22'h20_0004, instr = 32'h0000_0013.
//     -> next cycle pc_o = 64'hFFFF_FFFF_FFE0_0004, instr_o = 32'h13, misaligned = 0.
//     Push pc = 22'h00_0006 -> pc_o = 64'h6, misaligned = 1.
//  3. Fill and wrap: push 8 packets (pc = 4*i) with no pops.
//     -> count_o = 8 and ready_o = 0; a 9th push is refused. Pop 2, push 2 (pc = 32, 36), then
//     drain. -> pc order is 0,4,...,36 and the pointers wrap correctly.
//  4. Full plus simultaneous pop: with the queue full, assert fe_v_i and yumi together.
//     -> pop accepted, push refused, count_o = 7. Next cycle the push is accepted, count_o = 8.
//  5. Flush with concurrent traffic: 5 entries queued, flush_i = 1 together with fe_v_i and yumi.
//     -> next cycle count_o = 0 and v_o = 0. A push in the following cycle appears alone at the
//     head.
//  6. Randomised push/pop/flush for 10k cycles against a scoreboard model.
//     -> order, count_o and the no-fall-through latency match, with no yumi-when-empty assertion
//     firing.

Source files
------------

// File: rtl/bp_fe_fetch_queue.sv
// bp_fe_fetch_queue: FE-to-BE packet FIFO with flush, PC sign-extension and misalignment tag
module bp_fe_fetch_queue #(
  parameter int vaddr_width_p = 22,
  parameter int eaddr_width_p = 64,
  parameter int instr_width_p = 32,
  parameter int els_p = 8
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       flush_i,
  input  logic                       fe_v_i,
  input  logic [vaddr_width_p-1:0]   fe_pc_i,
  input  logic [instr_width_p-1:0]   fe_instr_i,
  output logic                       fe_ready_o,
  output logic                       fe_queue_v_o,
  output logic [eaddr_width_p-1:0]   fe_queue_pc_o,
  output logic [instr_width_p-1:0]   fe_queue_instr_o,
  output logic                       fe_queue_misaligned_o,
  input  logic                       fe_queue_yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);
  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p+1);
  logic [vaddr_width_p+instr_width_p-1:0] mem [els_p];
  logic [ptr_w-1:0] rd_ptr, wr_ptr;
  logic [cnt_w-1:0] count;
  logic push, pop;
  logic [vaddr_width_p-1:0] head_pc;
  logic [instr_width_p-1:0] head_instr;
  assign fe_ready_o = ~reset_i & (count != cnt_w'(els_p));
  assign fe_queue_v_o = count != '0;
  assign push = fe_v_i & fe_ready_o;
  assign pop = fe_queue_yumi_i & fe_queue_v_o;
  assign count_o = count;
  assign {head_pc, head_instr} = mem[rd_ptr];
  assign fe_queue_pc_o = fe_queue_v_o ? {{(eaddr_width_p-vaddr_width_p){head_pc[vaddr_width_p-1]}}, head_pc} : '0;
  assign fe_queue_instr_o = fe_queue_v_o ? head_instr : '0;
  assign fe_queue_misaligned_o = fe_queue_v_o & (|head_pc[1:0]);
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + ptr_w'(pop);
      wr_ptr <= wr_ptr + ptr_w'(push);
      count <= count + cnt_w'(push) - cnt_w'(pop);
    end
  always_ff @(posedge clk_i)
    if (push & ~flush_i) mem[wr_ptr] <= {fe_pc_i, fe_instr_i};
  always @(posedge clk_i)
    if (!reset_i) assert (!(fe_queue_yumi_i && !fe_queue_v_o));
endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// tb_bp_fe_fetch_queue: directed and randomised checks of the fetch queue against a queue model
module tb_bp_fe_fetch_queue;
  logic clk_i = 0, reset_i = 1, flush_i = 0, fe_v_i = 0, fe_queue_yumi_i = 0;
  logic [21:0] fe_pc_i = '0;
  logic [31:0] fe_instr_i = '0;
  logic fe_ready_o, fe_queue_v_o, fe_queue_misaligned_o;
  logic [63:0] fe_queue_pc_o;
  logic [31:0] fe_queue_instr_o;
  logic [3:0] count_o;
  int errors = 0, checks = 0;
  logic [53:0] model [$];

  bp_fe_fetch_queue dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .fe_v_i(fe_v_i), .fe_pc_i(fe_pc_i),
    .fe_instr_i(fe_instr_i), .fe_ready_o(fe_ready_o), .fe_queue_v_o(fe_queue_v_o),
    .fe_queue_pc_o(fe_queue_pc_o), .fe_queue_instr_o(fe_queue_instr_o),
    .fe_queue_misaligned_o(fe_queue_misaligned_o), .fe_queue_yumi_i(fe_queue_yumi_i),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic beat(input logic v, input logic [21:0] pc, input logic [31:0] ins, input logic y, input logic f);
    fe_v_i = v;
    fe_pc_i = pc;
    fe_instr_i = ins;
    fe_queue_yumi_i = y;
    flush_i = f;
    @(posedge clk_i);
    #1;
    fe_v_i = 0;
    fe_queue_yumi_i = 0;
    flush_i = 0;
  endtask

  initial begin
    #1;
    check("rst_ready", fe_ready_o, 0);
    check("rst_v", fe_queue_v_o, 0);
    check("rst_count", count_o, 0);
    @(posedge clk_i);
    #1 reset_i = 0;
    for (int i = 0; i < 3; i++) beat(1, 22'(i * 4 + 100), 32'(i), 0, 0);
    check("pre_rst_count", count_o, 3);
    #2 reset_i = 1;
    #1;
    check("async_rst_v", fe_queue_v_o, 0);
    check("async_rst_count", count_o, 0);
    check("async_rst_ready", fe_ready_o, 0);
    #1 reset_i = 0;
    @(posedge clk_i);
    #1;
    check("post_rst_ready", fe_ready_o, 1);
    check("post_rst_v", fe_queue_v_o, 0);

    fe_v_i = 1;
    fe_pc_i = 22'h20_0004;
    fe_instr_i = 32'h13;
    #1;
    check("no_fallthrough", fe_queue_v_o, 0);
    @(posedge clk_i);
    #1 fe_v_i = 0;
    check("sx_v", fe_queue_v_o, 1);
    check("sx_pc", fe_queue_pc_o, 64'hFFFF_FFFF_FFE0_0004);
    check("sx_instr", fe_queue_instr_o, 32'h13);
    check("sx_mis", fe_queue_misaligned_o, 0);
    beat(1, 22'h00_0006, 32'h55, 1, 0);
    check("pushpop_count", count_o, 1);
    check("mis_pc", fe_queue_pc_o, 64'h6);
    check("mis_flag", fe_queue_misaligned_o, 1);
    beat(0, 0, 0, 1, 0);
    check("empty_v", fe_queue_v_o, 0);
    check("empty_pc", fe_queue_pc_o, 0);

    for (int i = 0; i < 8; i++) beat(1, 22'(4 * i), 32'(i), 0, 0);
    check("full_count", count_o, 8);
    check("full_ready", fe_ready_o, 0);
    beat(1, 22'h3F, 0, 0, 0);
    check("refuse_count", count_o, 8);
    check("pop0_pc", fe_queue_pc_o, 0);
    beat(0, 0, 0, 1, 0);
    check("pop1_pc", fe_queue_pc_o, 4);
    beat(0, 0, 0, 1, 0);
    beat(1, 22'd32, 8, 0, 0);
    beat(1, 22'd36, 9, 0, 0);
    check("refill_count", count_o, 8);
    beat(1, 22'd40, 10, 1, 0);
    check("fullpop_count", count_o, 7);
    beat(1, 22'd40, 10, 0, 0);
    check("fullpop_refill", count_o, 8);
    for (int i = 3; i <= 10; i++) begin
      check($sformatf("drain_pc%0d", i), fe_queue_pc_o, 64'(4 * i));
      check($sformatf("drain_instr%0d", i), fe_queue_instr_o, 64'(i));
      beat(0, 0, 0, 1, 0);
    end
    check("drained_v", fe_queue_v_o, 0);

    for (int i = 0; i < 5; i++) beat(1, 22'(8 * i), 32'(i), 0, 0);
    check("preflush_count", count_o, 5);
    beat(1, 22'h77, 32'h77, 1, 1);
    check("flush_count", count_o, 0);
    check("flush_v", fe_queue_v_o, 0);
    check("flush_ready", fe_ready_o, 1);
    beat(1, 22'h100, 32'hABC, 0, 0);
    check("postflush_count", count_o, 1);
    check("postflush_pc", fe_queue_pc_o, 64'h100);
    check("postflush_instr", fe_queue_instr_o, 32'hABC);
    beat(1, 22'h0, 32'h0, 0, 1);

    for (int c = 0; c < 10000; c++) begin
      logic v, y, f;
      logic [21:0] pc;
      logic [31:0] ins;
      logic [53:0] h;
      int sz;
      v = 1'($urandom_range(0, 1));
      y = (model.size() != 0) && ($urandom_range(0, 2) != 0);
      f = $urandom_range(0, 49) == 0;
      pc = 22'($urandom);
      ins = $urandom;
      sz = model.size();
      check("rnd_count", count_o, 64'(sz));
      check("rnd_ready", fe_ready_o, 64'(sz != 8));
      check("rnd_v", fe_queue_v_o, 64'(sz != 0));
      if (sz != 0) begin
        h = model[0];
        check("rnd_pc", fe_queue_pc_o, {{42{h[53]}}, h[53:32]});
        check("rnd_instr", fe_queue_instr_o, 64'(h[31:0]));
        check("rnd_mis", fe_queue_misaligned_o, 64'(|h[33:32]));
      end
      if (f) model.delete();
      else begin
        if (y) void'(model.pop_front());
        if (v && sz != 8) model.push_back({pc, ins});
      end
      beat(v, pc, ins, y, f);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
